// File: rtl/io_controller.sv
// -----------------------------------------------------------------------------
// io_controller
//   Handshake between the CPU datapath and the seven-segment display stage for
//   IN/OUT instructions. The CPU is stalled until the operator confirms with a
//   debounced pushbutton. IN returns the sign-extended switch value; OUT
//   latches the register value for display.
//
// Parameters
//   DEBOUNCE_CYCLES : stable cycles before a key level change is accepted (>=2)
//   SW_WIDTH        : number of slide switches (2..32)
//
// Ports
//   clock, reset    : system clock, synchronous active-high reset
//   io_in_req       : CPU executing IN (held while io_stall)
//   io_out_req      : CPU executing OUT (held while io_stall)
//   cpu_data[31:0]  : register value for OUT
//   switches        : raw asynchronous slide switches (two's complement)
//   key_n           : raw asynchronous active-low confirm button
//   io_stall        : CPU must hold its state
//   in_data[31:0]   : captured sign-extended switch value
//   in_valid        : one-cycle write strobe for in_data
//   binaryS[31:0]   : value for the display stage
//   in_on, out_on   : display-stage mode flags
// -----------------------------------------------------------------------------
module io_controller #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int SW_WIDTH        = 18
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                io_in_req,
  input  logic                io_out_req,
  input  logic [31:0]         cpu_data,
  input  logic [SW_WIDTH-1:0] switches,
  input  logic                key_n,
  output logic                io_stall,
  output logic [31:0]         in_data,
  output logic                in_valid,
  output logic [31:0]         binaryS,
  output logic                in_on,
  output logic                out_on
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_IN_WAIT  = 3'd1,
    ST_IN_ACK   = 3'd2,
    ST_OUT_WAIT = 3'd3,
    ST_OUT_ACK  = 3'd4
  } state_e;

  // Registers and their next-state values
  logic [SW_WIDTH-1:0] sw_meta_q, sw_meta_d;
  logic [SW_WIDTH-1:0] sw_sync_q, sw_sync_d;
  logic                key_meta_q, key_meta_d;
  logic                key_sync_q, key_sync_d;
  logic                key_deb_q, key_deb_d;
  logic                key_deb_prev_q, key_deb_prev_d;
  logic [CNT_W-1:0]    deb_cnt_q, deb_cnt_d;
  state_e              state_q, state_d;
  logic [31:0]         in_data_q, in_data_d;
  logic [31:0]         out_reg_q, out_reg_d;
  logic                shown_q, shown_d;

  logic [31:0]         sw_ext_s;
  logic                press_s;

  // Synchronizer next-state: plain two-stage shift of the asynchronous inputs
  always_comb begin
    sw_meta_d      = switches;
    sw_sync_d      = sw_meta_q;
    key_meta_d     = key_n;
    key_sync_d     = key_meta_q;
    key_deb_prev_d = key_deb_q;
  end

  // Sign extension of the synchronized switches (cast handles SW_WIDTH == 32)
  always_comb begin
    sw_ext_s = 32'($signed(sw_sync_q));
  end

  // Debouncer: any cycle agreeing with the accepted level restarts the count
  always_comb begin
    key_deb_d = key_deb_q;
    deb_cnt_d = deb_cnt_q;
    if (key_sync_q == key_deb_q) begin
      deb_cnt_d = {CNT_W{1'b0}};
    end else if (deb_cnt_q == CNT_LAST) begin
      key_deb_d = ~key_deb_q;
      deb_cnt_d = {CNT_W{1'b0}};
    end else begin
      deb_cnt_d = deb_cnt_q + CNT_W'(1);
    end
  end

  // Falling edge of the debounced level: one strobe per accepted press
  always_comb begin
    press_s = key_deb_prev_q & ~key_deb_q;
  end

  // FSM next-state, datapath register updates and Moore outputs
  always_comb begin
    state_d   = state_q;
    in_data_d = in_data_q;
    out_reg_d = out_reg_q;
    shown_d   = shown_q;
    io_stall  = 1'b0;
    in_valid  = 1'b0;
    in_on     = 1'b0;
    out_on    = 1'b0;
    binaryS   = out_reg_q;
    case (state_q)
      ST_IDLE: begin
        out_on = shown_q;
        // IN has priority; out_reg is only touched by a lone OUT request
        if (io_in_req) begin
          state_d = ST_IN_WAIT;
          shown_d = 1'b0;
        end else if (io_out_req) begin
          state_d   = ST_OUT_WAIT;
          out_reg_d = cpu_data;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_IN_WAIT: begin
        io_stall = 1'b1;
        in_on    = 1'b1;
        binaryS  = sw_ext_s;
        if (press_s) begin
          in_data_d = sw_ext_s;
          state_d   = ST_IN_ACK;
        end else begin
          state_d = ST_IN_WAIT;
        end
      end
      ST_IN_ACK: begin
        in_valid = 1'b1;
        in_on    = 1'b1;
        binaryS  = in_data_q;
        state_d  = ST_IDLE;
      end
      ST_OUT_WAIT: begin
        io_stall = 1'b1;
        out_on   = 1'b1;
        if (press_s) begin
          state_d = ST_OUT_ACK;
        end else begin
          state_d = ST_OUT_WAIT;
        end
      end
      ST_OUT_ACK: begin
        out_on  = 1'b1;
        shown_d = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output data register is a direct view of the captured value
  always_comb begin
    in_data = in_data_q;
  end

  // All state registers, synchronous active-high reset
  always_ff @(posedge clock) begin
    if (reset) begin
      sw_meta_q      <= {SW_WIDTH{1'b0}};
      sw_sync_q      <= {SW_WIDTH{1'b0}};
      key_meta_q     <= 1'b1;
      key_sync_q     <= 1'b1;
      key_deb_q      <= 1'b1;
      key_deb_prev_q <= 1'b1;
      deb_cnt_q      <= {CNT_W{1'b0}};
      state_q        <= ST_IDLE;
      in_data_q      <= 32'd0;
      out_reg_q      <= 32'd0;
      shown_q        <= 1'b0;
    end else begin
      sw_meta_q      <= sw_meta_d;
      sw_sync_q      <= sw_sync_d;
      key_meta_q     <= key_meta_d;
      key_sync_q     <= key_sync_d;
      key_deb_q      <= key_deb_d;
      key_deb_prev_q <= key_deb_prev_d;
      deb_cnt_q      <= deb_cnt_d;
      state_q        <= state_d;
      in_data_q      <= in_data_d;
      out_reg_q      <= out_reg_d;
      shown_q        <= shown_d;
    end
  end

endmodule

// File: tb/tb_io_controller.sv
// -----------------------------------------------------------------------------
// tb_io_controller
//   Directed bench for io_controller with DEBOUNCE_CYCLES=4, SW_WIDTH=18.
//   Inputs change just after a falling edge; outputs are checked on falling
//   edges, half a cycle away from the active rising edge.
// -----------------------------------------------------------------------------
module tb_io_controller;

  logic        clock;
  logic        reset;
  logic        io_in_req;
  logic        io_out_req;
  logic [31:0] cpu_data;
  logic [17:0] switches;
  logic        key_n;
  logic        io_stall;
  logic [31:0] in_data;
  logic        in_valid;
  logic [31:0] binaryS;
  logic        in_on;
  logic        out_on;

  int n_cmp = 0;
  int n_err = 0;
  int n_inv = 0;

  io_controller #(.DEBOUNCE_CYCLES(4), .SW_WIDTH(18)) dut (
    .clock      (clock),
    .reset      (reset),
    .io_in_req  (io_in_req),
    .io_out_req (io_out_req),
    .cpu_data   (cpu_data),
    .switches   (switches),
    .key_n      (key_n),
    .io_stall   (io_stall),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .binaryS    (binaryS),
    .in_on      (in_on),
    .out_on     (out_on)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Count in_valid cycles as seen by the CPU at each rising edge
  always @(posedge clock) begin
    if (in_valid === 1'b1) n_inv <= n_inv + 1;
  end

  task automatic step(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; io_in_req = 1'b0; io_out_req = 1'b0; cpu_data = 32'd0;
    switches = 18'h3FFFB; key_n = 1'b1;
    step(3);
    reset = 1'b0;
    chk("rst_stall", io_stall, 32'd0);
    chk("rst_inv", in_valid, 32'd0);
    chk("rst_in_on", in_on, 32'd0);
    chk("rst_out_on", out_on, 32'd0);
    chk("rst_bin", binaryS, 32'd0);
    chk("rst_in_data", in_data, 32'd0);

    // IN with negative switch value, key low from edge 1
    io_in_req = 1'b1; key_n = 1'b0;
    for (int e = 1; e <= 6; e++) begin
      step(1);
      chk("in1_stall", io_stall, 32'd1);
      chk("in1_in_on", in_on, 32'd1);
      chk("in1_inv", in_valid, 32'd0);
    end
    chk("in1_bin_live", binaryS, 32'hFFFFFFFB);
    chk("in1_out_on", out_on, 32'd0);
    step(1);  // edge 7: IN_ACK
    chk("in1_ack_inv", in_valid, 32'd1);
    chk("in1_ack_stall", io_stall, 32'd0);
    chk("in1_ack_data", in_data, 32'hFFFFFFFB);
    chk("in1_ack_in_on", in_on, 32'd1);
    io_in_req = 1'b0; key_n = 1'b1;
    step(1);
    chk("in1_idle_inv", in_valid, 32'd0);
    chk("in1_idle_in_on", in_on, 32'd0);
    chk("in1_hold_data", in_data, 32'hFFFFFFFB);
    step(8);

    // OUT of 123456
    cpu_data = 32'd123456; io_out_req = 1'b1;
    step(1);
    chk("out_stall", io_stall, 32'd1);
    chk("out_out_on", out_on, 32'd1);
    chk("out_in_on", in_on, 32'd0);
    chk("out_bin", binaryS, 32'd123456);
    step(3);
    chk("out_stall_wait", io_stall, 32'd1);
    key_n = 1'b0;
    step(6);
    chk("out_stall_e6", io_stall, 32'd1);
    step(1);
    chk("out_ack_stall", io_stall, 32'd0);
    chk("out_ack_out_on", out_on, 32'd1);
    chk("out_ack_inv", in_valid, 32'd0);
    io_out_req = 1'b0; key_n = 1'b1; cpu_data = 32'd0; switches = 18'h00005;
    step(1);
    chk("out_idle_stall", io_stall, 32'd0);
    chk("out_idle_shown", out_on, 32'd1);
    chk("out_idle_bin", binaryS, 32'd123456);
    step(8);

    // IN clears the shown value; bouncy key gives no press
    io_in_req = 1'b1;
    step(1);
    chk("in2_out_on_clr", out_on, 32'd0);
    chk("in2_in_on", in_on, 32'd1);
    chk("in2_bin", binaryS, 32'd5);
    chk("in2_stall", io_stall, 32'd1);
    repeat (3) begin
      key_n = 1'b0; step(3);
      key_n = 1'b1; step(1);
    end
    step(4);
    chk("bounce_stall", io_stall, 32'd1);
    chk("bounce_no_press", n_inv, 32'd1);
    key_n = 1'b0; step(4);
    key_n = 1'b1; step(2);
    chk("in2_stall_e6", io_stall, 32'd1);
    step(1);
    chk("in2_ack_inv", in_valid, 32'd1);
    chk("in2_ack_data", in_data, 32'd5);
    io_in_req = 1'b0; switches = 18'h1FFFF;
    step(1);
    chk("in2_idle_inv", in_valid, 32'd0);
    step(8);
    chk("in2_one_press", n_inv, 32'd2);

    // Held key across two IN instructions
    io_in_req = 1'b1; key_n = 1'b0;
    step(7);
    chk("held1_ack_inv", in_valid, 32'd1);
    chk("held1_data", in_data, 32'h0001FFFF);
    io_in_req = 1'b0;
    step(1);
    chk("held1_idle_stall", io_stall, 32'd0);
    io_in_req = 1'b1;
    step(15);
    chk("held2_stall", io_stall, 32'd1);
    chk("held2_in_on", in_on, 32'd1);
    chk("held2_no_repeat", n_inv, 32'd3);
    key_n = 1'b1; switches = 18'h20000;
    step(8);
    chk("held2_release_stall", io_stall, 32'd1);
    chk("held2_bin", binaryS, 32'hFFFE0000);
    key_n = 1'b0;
    step(6);
    chk("held2_stall_e6", io_stall, 32'd1);
    step(1);
    chk("held2_ack_inv", in_valid, 32'd1);
    chk("held2_data", in_data, 32'hFFFE0000);
    io_in_req = 1'b0; key_n = 1'b1;
    step(9);

    // Simultaneous requests: IN wins, out_reg untouched
    io_in_req = 1'b1; io_out_req = 1'b1; cpu_data = 32'hDEADBEEF;
    step(1);
    chk("sim_in_on", in_on, 32'd1);
    chk("sim_out_on", out_on, 32'd0);
    chk("sim_stall", io_stall, 32'd1);
    key_n = 1'b0;
    step(7);
    chk("sim_ack_inv", in_valid, 32'd1);
    io_in_req = 1'b0; io_out_req = 1'b0; key_n = 1'b1;
    step(1);
    chk("sim_out_reg", binaryS, 32'd123456);
    chk("sim_idle_out_on", out_on, 32'd0);
    step(8);

    // Reset while in OUT_WAIT with a partial key count
    cpu_data = 32'hCAFE0001; io_out_req = 1'b1;
    step(1);
    chk("rst2_pre_stall", io_stall, 32'd1);
    chk("rst2_pre_bin", binaryS, 32'hCAFE0001);
    key_n = 1'b0;
    step(3);
    reset = 1'b1;
    step(1);
    chk("rst2_stall", io_stall, 32'd0);
    chk("rst2_inv", in_valid, 32'd0);
    chk("rst2_in_on", in_on, 32'd0);
    chk("rst2_out_on", out_on, 32'd0);
    chk("rst2_bin", binaryS, 32'd0);
    chk("rst2_in_data", in_data, 32'd0);
    chk("rst2_key_deb", {31'd0, dut.key_deb_q}, 32'd1);
    reset = 1'b0; io_out_req = 1'b0; key_n = 1'b1;
    step(1);
    chk("rst2_idle_stall", io_stall, 32'd0);
    chk("total_in_valid", n_inv, 32'd5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
